// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port arbiter for the single data-memory port. Port 0 is
//                the CPU, port 1 a secondary master (debug/loader/DMA).
//                req/ack handshake, round-robin or fixed-priority grant FSM,
//                combinational stall back to the CPU while its access waits.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk_in,
    input  logic              reset,
    // port 0 (CPU)
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [1:0]        dms0,
    input  logic [2:0]        dml0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              cpu_stall,
    // port 1 (secondary master)
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [1:0]        dms1,
    input  logic [2:0]        dml1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    // data memory
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_dms,
    output logic [2:0]        mem_dml,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_last_grant;

    // State register; last_grant remembers which port was served most recently.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;   // port 0 wins the first round-robin tie
        end else begin
            r_state <= w_next;
            if (r_state == ST_G0) begin
                r_last_grant <= 1'b0;
            end else if (r_state == ST_G1) begin
                r_last_grant <= 1'b1;
            end
        end
    end

    // Next-state logic. The port just served is ignored for one cycle, so a
    // still-high req after ack is taken up again from IDLE (or from the other
    // port's grant). With fixed priority, G0 always returns to IDLE so that a
    // continuously requesting CPU keeps winning over port 1.
    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    if (FIXED_PRI != 0) begin
                        w_next = ST_G0;
                    end else begin
                        w_next = r_last_grant ? ST_G0 : ST_G1;
                    end
                end else if (req0) begin
                    w_next = ST_G0;
                end else if (req1) begin
                    w_next = ST_G1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_G0:   w_next = (req1 && (FIXED_PRI == 0)) ? ST_G1 : ST_IDLE;
            ST_G1:   w_next = req0 ? ST_G0 : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Output mux: the granted port's fields go to memory and its ack is raised.
    // Everything is forced to zero while reset is high so that a reset landing
    // in a grant cycle can never commit a write.
    always_comb begin
        ack0      = 1'b0;
        ack1      = 1'b0;
        rdata0    = '0;
        rdata1    = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_dms   = '0;
        mem_dml   = '0;
        if (!reset) begin
            case (r_state)
                ST_G0: begin
                    ack0      = 1'b1;
                    rdata0    = mem_rdata;
                    mem_we    = we0;
                    mem_addr  = addr0;
                    mem_wdata = wdata0;
                    mem_dms   = dms0;
                    mem_dml   = dml0;
                end
                ST_G1: begin
                    ack1      = 1'b1;
                    rdata1    = mem_rdata;
                    mem_we    = we1;
                    mem_addr  = addr1;
                    mem_wdata = wdata1;
                    mem_dms   = dms1;
                    mem_dml   = dml1;
                end
                default: begin
                    ack0 = 1'b0;
                end
            endcase
        end
    end

    // CPU stalls whenever it requests and is not being acknowledged this cycle.
    assign cpu_stall = req0 & ~reset & ~ack0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter with a scoreboard of
//                expected accesses and a small word-addressed memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [1:0]  dms0, dms1;
    logic [2:0]  dml0, dml1;
    logic        ack0, ack1, cpu_stall, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_dms;
    logic [2:0]  mem_dml;

    logic        fp_ack0, fp_ack1, fp_stall, fp_mem_we;
    logic [31:0] fp_rdata0, fp_rdata1, fp_mem_addr, fp_mem_wdata;
    logic [1:0]  fp_mem_dms;
    logic [2:0]  fp_mem_dml;

    always #5 clk_in = ~clk_in;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRI(0)) dut (
        .clk_in(clk_in), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .dms0(dms0), .dml0(dml0),
        .ack0(ack0), .rdata0(rdata0), .cpu_stall(cpu_stall),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .dms1(dms1), .dml1(dml1),
        .ack1(ack1), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_dms(mem_dms), .mem_dml(mem_dml), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRI(1)) dut_fp (
        .clk_in(clk_in), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .dms0(dms0), .dml0(dml0),
        .ack0(fp_ack0), .rdata0(fp_rdata0), .cpu_stall(fp_stall),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .dms1(dms1), .dml1(dml1),
        .ack1(fp_ack1), .rdata1(fp_rdata1),
        .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
        .mem_dms(fp_mem_dms), .mem_dml(fp_mem_dml), .mem_rdata(32'h0)
    );

    // Memory model: 64 words, combinational read, write on the rising edge.
    logic        mem_init;
    logic [31:0] mem [0:63];
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk_in) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= (i == 4) ? 32'hDEADBEEF : 32'h1000_0000 + i;
            end
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  dms;
        logic [2:0]  dml;
        logic [31:0] rdata;
    } acc_t;

    acc_t stim0[$], stim1[$], exp0[$], exp1[$];
    int   hist[$];
    int   n_tests = 0, n_fail = 0;
    int   stall_cnt, we_cnt;
    logic sb_en;
    logic a0_seen, a1_seen;

    function automatic acc_t mk(logic we, logic [31:0] addr, logic [31:0] wdata,
                                logic [1:0] dms, logic [2:0] dml, logic [31:0] rdata);
        acc_t a;
        a.we = we; a.addr = addr; a.wdata = wdata; a.dms = dms; a.dml = dml; a.rdata = rdata;
        return a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic present0();
        acc_t a;
        if (stim0.size() > 0) begin
            a = stim0.pop_front();
            req0 = 1'b1; we0 = a.we; addr0 = a.addr; wdata0 = a.wdata; dms0 = a.dms; dml0 = a.dml;
            exp0.push_back(a);
        end else begin
            req0 = 1'b0;
        end
    endtask

    task automatic present1();
        acc_t a;
        if (stim1.size() > 0) begin
            a = stim1.pop_front();
            req1 = 1'b1; we1 = a.we; addr1 = a.addr; wdata1 = a.wdata; dms1 = a.dms; dml1 = a.dml;
            exp1.push_back(a);
        end else begin
            req1 = 1'b0;
        end
    endtask

    // Mid-cycle observation: protocol invariants plus scoreboard pop on ack.
    task automatic monitor();
        acc_t e;
        a0_seen = ack0;
        a1_seen = ack1;
        hist.push_back(ack0 ? 1 : (ack1 ? 2 : 0));
        if (cpu_stall) stall_cnt++;
        if (mem_we) we_cnt++;
        check("ack_onehot", {31'b0, ack0 & ack1}, 32'h0);
        check("cpu_stall", {31'b0, cpu_stall}, {31'b0, req0 & ~ack0 & ~reset});
        if (!ack0 && !ack1) begin
            check("idle_mem_we", {31'b0, mem_we}, 32'h0);
            check("idle_mem_addr", mem_addr, 32'h0);
        end
        if (sb_en && ack0) begin
            if (exp0.size() == 0) begin
                check("p0_unexpected_ack", 32'h1, {31'b0, req0 & 1'b0});
            end else begin
                e = exp0.pop_front();
                check("p0_mem_we", {31'b0, mem_we}, {31'b0, e.we});
                check("p0_mem_addr", mem_addr, e.addr);
                check("p0_mem_dms", {30'b0, mem_dms}, {30'b0, e.dms});
                check("p0_mem_dml", {29'b0, mem_dml}, {29'b0, e.dml});
                if (e.we) check("p0_mem_wdata", mem_wdata, e.wdata);
                else      check("p0_rdata", rdata0, e.rdata);
                check("p0_other_rdata", rdata1, 32'h0);
            end
        end
        if (sb_en && ack1) begin
            if (exp1.size() == 0) begin
                check("p1_unexpected_ack", 32'h1, {31'b0, req1 & 1'b0});
            end else begin
                e = exp1.pop_front();
                check("p1_mem_we", {31'b0, mem_we}, {31'b0, e.we});
                check("p1_mem_addr", mem_addr, e.addr);
                check("p1_mem_dms", {30'b0, mem_dms}, {30'b0, e.dms});
                check("p1_mem_dml", {29'b0, mem_dml}, {29'b0, e.dml});
                if (e.we) check("p1_mem_wdata", mem_wdata, e.wdata);
                else      check("p1_rdata", rdata1, e.rdata);
                check("p1_other_rdata", rdata0, 32'h0);
            end
        end
    endtask

    // One clock cycle: observe at the falling edge, then present the next
    // request on any port that was just acknowledged.
    task automatic cyc();
        @(negedge clk_in);
        monitor();
        @(posedge clk_in);
        #1;
        if (sb_en && a0_seen) present0();
        if (sb_en && a1_seen) present1();
    endtask

    task automatic run_drain(input int max_cycles);
        int n = 0;
        while ((req0 || req1 || exp0.size() > 0 || exp1.size() > 0) && n < max_cycles) begin
            cyc();
            n++;
        end
        check("drain_timeout", exp0.size() + exp1.size() + {31'b0, req0} + {31'b0, req1}, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) begin
            @(posedge clk_in);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic start();
        stall_cnt = 0; we_cnt = 0;
        hist.delete();
        present0();
        present1();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mem_init = 1'b1; sb_en = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; dms0 = 0; dml0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; dms1 = 0; dml1 = 0;
        a0_seen = 0; a1_seen = 0; stall_cnt = 0; we_cnt = 0;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        mem_init = 1'b0;

        // Reset state: outputs zero, stall masked even with req0 high.
        req0 = 1'b1;
        @(negedge clk_in);
        check("rst_ack", {30'b0, ack0, ack1}, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        check("rst_mem_bus", mem_addr | mem_wdata | {27'b0, mem_dms, mem_dml}, 32'h0);
        check("rst_stall", {31'b0, cpu_stall}, 32'h0);
        @(posedge clk_in); #1;
        req0 = 1'b0;
        reset = 1'b0;

        // Single CPU load: one stall cycle, no write.
        stim0.push_back(mk(1'b0, 32'h10, 32'h0, 2'b00, 3'b000, 32'hDEADBEEF));
        start();
        run_drain(20);
        check("load_stall_cycles", stall_cnt, 32'd1);
        check("load_no_write", we_cnt, 32'd0);

        // CPU store lands in memory.
        stim0.push_back(mk(1'b1, 32'h20, 32'h12345678, 2'b00, 3'b000, 32'h0));
        start();
        run_drain(20);
        check("store_we_cycles", we_cnt, 32'd1);
        check("store_mem_content", mem[8], 32'h12345678);

        // Round-robin from reset: 0,1,0,1 with no idle gap.
        do_reset();
        stim0.push_back(mk(1'b0, 32'h14, 32'h0, 2'b00, 3'b000, 32'h1000_0005));
        stim0.push_back(mk(1'b0, 32'h18, 32'h0, 2'b00, 3'b101, 32'h1000_0006));
        stim1.push_back(mk(1'b1, 32'h50, 32'hA5A5A5A5, 2'b10, 3'b000, 32'h0));
        stim1.push_back(mk(1'b0, 32'h44, 32'h0, 2'b01, 3'b010, 32'h1000_0011));
        start();
        run_drain(30);
        check("rr_hist_len", hist.size(), 32'd5);
        if (hist.size() == 5) begin
            check("rr_slot0", hist[0], 32'd0);
            check("rr_slot1", hist[1], 32'd1);
            check("rr_slot2", hist[2], 32'd2);
            check("rr_slot3", hist[3], 32'd1);
            check("rr_slot4", hist[4], 32'd2);
        end
        check("rr_store_content", mem[20], 32'hA5A5A5A5);

        // Both held continuously: fixed priority starves port 1, round-robin alternates.
        do_reset();
        sb_en = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; dms0 = 2'b00; dml0 = 3'b000;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0; dms1 = 2'b00; dml1 = 3'b000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            check("fp_ack0", {31'b0, fp_ack0}, {31'b0, (i % 2) == 1});
            check("fp_ack1", {31'b0, fp_ack1}, 32'h0);
            check("fp_stall", {31'b0, fp_stall}, {31'b0, (i % 2) == 0});
            check("fp_bus_zero", fp_mem_addr | fp_mem_wdata | fp_rdata0 | fp_rdata1
                  | {27'b0, fp_mem_dms, fp_mem_dml} | {31'b0, fp_mem_we}, 32'h0);
            check("rr_held_ack0", {31'b0, ack0}, {31'b0, (i % 2) == 1});
            check("rr_held_ack1", {31'b0, ack1}, {31'b0, (i >= 2) && ((i % 2) == 0)});
            @(posedge clk_in); #1;
        end
        sb_en = 1'b1;
        do_reset();

        // Back-to-back port 1 only: ack every second cycle, new address each time.
        stim1.push_back(mk(1'b0, 32'h40, 32'h0, 2'b00, 3'b001, 32'h1000_0010));
        stim1.push_back(mk(1'b0, 32'h44, 32'h0, 2'b00, 3'b100, 32'h1000_0011));
        stim1.push_back(mk(1'b0, 32'h48, 32'h0, 2'b00, 3'b011, 32'h1000_0012));
        start();
        run_drain(30);
        check("b2b_hist_len", hist.size(), 32'd6);
        if (hist.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("b2b_slot", hist[i], (i % 2) ? 32'd2 : 32'd0);
            end
        end

        // Reset asserted during a G0 store: no write, back to IDLE.
        sb_en = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h30; wdata0 = 32'hCAFEF00D; dms0 = 2'b00; dml0 = 3'b000;
        @(negedge clk_in);
        check("rg0_pre_ack", {31'b0, ack0}, 32'h0);
        check("rg0_pre_stall", {31'b0, cpu_stall}, 32'h1);
        @(posedge clk_in); #1;
        reset = 1'b1;
        @(negedge clk_in);
        check("rg0_mem_we", {31'b0, mem_we}, 32'h0);
        check("rg0_ack", {30'b0, ack0, ack1}, 32'h0);
        check("rg0_mem_addr", mem_addr, 32'h0);
        check("rg0_stall", {31'b0, cpu_stall}, 32'h0);
        @(posedge clk_in); #1;
        reset = 1'b0;
        req0 = 1'b0;
        @(negedge clk_in);
        check("rg0_after_ack", {30'b0, ack0, ack1}, 32'h0);
        check("rg0_after_bus", mem_addr | mem_wdata | {27'b0, mem_dms, mem_dml} | {31'b0, mem_we}, 32'h0);
        check("rg0_mem_unchanged", mem[12], 32'h1000_000C);
        @(posedge clk_in); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (write enable, address, write data, store-width select, load-type select, read data) between two requesters.
  - Port 0: the CPU.
  - Port 1: a secondary master (debug/loader/DMA).
- Sits between the requesters and the data memory in the top-level computer.
- Uses a req/ack handshake and a small grant FSM with round-robin or fixed priority.
- Drives a stall to the CPU while its access is pending.

Parameters:
- ADDR_W, 32, width of the address bus.
- DATA_W, 32, width of the read/write data buses.
- FIXED_PRI, 0, 0 = round-robin between ports; 1 = port 0 always wins when both request in IDLE.

Ports:
- clk_in  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 (CPU) access request.
- we0  in  1  port 0 write enable (1 = store, 0 = load).
- addr0  in  ADDR_W  port 0 byte address.
- wdata0  in  DATA_W  port 0 store data.
- dms0  in  2  port 0 store-width select.
- dml0  in  3  port 0 load-type select.
- ack0  out  1  port 0 access completes this cycle.
- rdata0  out  DATA_W  port 0 load data, valid when ack0=1.
- cpu_stall  out  1  req0 & ~ack0.
- req1, we1, addr1, wdata1, dms1, dml1  in  same widths as port 0  port 1 request fields.
- ack1  out  1  port 1 access completes this cycle.
- rdata1  out  DATA_W  port 1 load data, valid when ack1=1.
- mem_we  out  1  data-memory write enable.
- mem_addr  out  ADDR_W  data-memory address.
- mem_wdata  out  DATA_W  data-memory write data.
- mem_dms  out  2  data-memory store-width select.
- mem_dml  out  3  data-memory load-type select.
- mem_rdata  in  DATA_W  data-memory read data (combinational read of mem_addr).

Behaviour:
- FSM states: IDLE, G0 (port 0 granted), G1 (port 1 granted). Registered; last_grant register holds 1 bit.
- Reset (synchronous): state=IDLE, last_grant=1 (so port 0 wins first round-robin tie).
- Reset outputs: ack0=ack1=0; mem_we=0; mem_addr/mem_wdata/mem_dms/mem_dml=0.
- mem_we is gated by ~reset: no memory write during any cycle in which reset=1, including reset asserted while in G0/G1.
- IDLE:
  - Memory outputs are 0 and acks are 0.
  - Only req0 → G0; only req1 → G1; neither → stay in IDLE.
  - Both, round-robin: grant the port ≠ last_grant.
  - Both, FIXED_PRI=1: always G0.
- Gx (x = 0 or 1):
  - Memory outputs mux port x fields; mem_we=wex; ackx=1.
  - rdatax=mem_rdata; the other port's rdata=0.
  - last_grant←x at the clock edge.
  - The write commits at the rising edge ending the Gx cycle.
- Next state from Gx: if the other port requests → G(other); else → IDLE.
  - The just-served port's req is ignored for one cycle.
  - Back-to-back accesses from one port therefore cost 2 cycles each; alternating ports sustain 1 access/cycle.
- Latency: req sampled high in IDLE at edge N gives ack during cycle N+1. Minimum one stall cycle for the CPU per access.
- Requester contract:
  - Hold req and all fields stable from assertion until the cycle ack is high.
  - After ack, drop req or re-present a new request; a req still high the next cycle is a new access.
- Requests dropped before ack: an Gx transition is already committed once sampled; the access completes with the fields present during Gx. Requesters must not drop req early.
- Starvation: round-robin guarantees each requesting port is acknowledged within 2 grant slots. With FIXED_PRI=1, port 1 can starve (documented, acceptable for debug use).
- Acks are one-hot; never both high.
- cpu_stall is combinational and is 0 during reset (req0 masked by reset).

Test Plan:
- Reset, then single CPU load: req0=1, we0=0, addr0=0x10, dml0=3'b000, mem_rdata=0xDEADBEEF → ack0=1 one cycle after req0, rdata0=0xDEADBEEF; cpu_stall=1 exactly one cycle; mem_we stays 0.
- CPU store: req0=1, we0=1, addr0=0x20, wdata0=0x12345678, dms0=2'b00 → in G0 cycle mem_we=1, mem_addr=0x20, mem_wdata=0x12345678, mem_dms=0; after the edge, the memory model holds the value.
- Simultaneous requests after reset, FIXED_PRI=0 → G0 first (ack0), G1 next cycle (ack1), no IDLE gap; repeat with both held → grants alternate 0,1,0,1.
- FIXED_PRI=1, both requesting continuously → ack0 on every other cycle, ack1 never asserted.
- Back-to-back port 1 only: req1 held with changing addr → ack1 every 2nd cycle, mem_addr matches the field value in each G1 cycle.
- Reset asserted during G0 with we0=1 → mem_we=0 that cycle, next cycle state IDLE, all outputs 0, no memory change.
